regfile_sb: RTL and testbench

//  Parametrised CPU general-purpose register file: 2 combinational read ports, 1 clocked write port.

---
 rtl/regfile_sb.sv | 113 +++++++++++
 tb/tb_regfile_sb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with two combinational read
// ports, one clocked write port, an optional hardwired-zero register 0,
// optional writeback-to-read bypass and a per-register busy scoreboard.
// Issue marks a destination pending and writeback releases it. The busy
// outputs feed the decode-stage hazard stall.
module regfile_sb #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned AW       = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic             We,
   input  logic [AW-1:0]    Wa,
   input  logic [WIDTH-1:0] Wd,
   input  logic [AW-1:0]    Ra1,
   input  logic [AW-1:0]    Ra2,
   output logic [WIDTH-1:0] Rd1,
   output logic [WIDTH-1:0] Rd2,
   input  logic             Iss,
   input  logic [AW-1:0]    Ia,
   output logic             Busy1,
   output logic             Busy2,
   output logic             Busy_any
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   logic wr_ok_c;
   logic zero1_c;
   logic zero2_c;
   logic hit1_c;
   logic hit2_c;

   // Writes to the hardwired-zero register are dropped.
   assign wr_ok_c = We && !(ZERO_REG && (Wa == '0));

   // Register array: asynchronous clear, one write per clock.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok_c) begin
         mem_q[Wa] <= Wd;
      end
   end

   // Scoreboard next state: a writeback clears, an issue sets, and the set
   // wins when both target the same register on the same edge.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (Iss && (Ia == AW'(i))) begin
            busy_d[i] = 1'b1;
         end else if (We && (Wa == AW'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
      if (ZERO_REG) begin
         busy_d[0] = 1'b0;
      end
   end

   // Scoreboard state register.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Per-port decode of the zero register and of a same-cycle writeback hit.
   always_comb begin
      zero1_c = ZERO_REG && (Ra1 == '0);
      zero2_c = ZERO_REG && (Ra2 == '0);
      hit1_c  = BYPASS && We && (Wa == Ra1);
      hit2_c  = BYPASS && We && (Wa == Ra2);
   end

   // Read ports: zero register, then the bypassed writeback, then storage.
   always_comb begin
      if (zero1_c) begin
         Rd1 = '0;
      end else if (hit1_c) begin
         Rd1 = Wd;
      end else begin
         Rd1 = mem_q[Ra1];
      end
      if (zero2_c) begin
         Rd2 = '0;
      end else if (hit2_c) begin
         Rd2 = Wd;
      end else begin
         Rd2 = mem_q[Ra2];
      end
   end

   // Hazard status: a bypassed writeback hides the pending producer.
   // Busy_any reflects the stored scoreboard only.
   always_comb begin
      Busy1    = busy_q[Ra1] && !hit1_c;
      Busy2    = busy_q[Ra2] && !hit2_c;
      Busy_any = |busy_q;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: three register-file configurations are driven by one shared
// stimulus stream. Each configuration takes the low address and data bits it
// needs. A reference model of the register array and the busy set is checked
// against every instance on each falling clock edge. Directed literal checks
// pin the model and the boundary cases.
module tb_regfile_sb;

   logic        Clk;
   logic        Clrn;
   logic        We;
   logic        Iss;
   logic [5:0]  Wa;
   logic [5:0]  Ra1;
   logic [5:0]  Ra2;
   logic [5:0]  Ia;
   logic [63:0] Wd;

   // cfg0: 32x5, zero reg, bypass. cfg1: 32x5, plain. cfg2: 64x6, zero reg, bypass.
   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic [63:0] rd1_c, rd2_c;
   logic        b1_a, b2_a, ba_a, b1_b, b2_b, ba_b, b1_c, b2_c, ba_c;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: register contents and busy flags per configuration.
   logic [63:0] m_mem [3][64];
   bit          m_bsy [3][64];

   regfile_sb #(.WIDTH(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
      .Clk(Clk), .Clrn(Clrn), .We(We), .Wa(Wa[4:0]), .Wd(Wd[31:0]),
      .Ra1(Ra1[4:0]), .Ra2(Ra2[4:0]), .Rd1(rd1_a), .Rd2(rd2_a),
      .Iss(Iss), .Ia(Ia[4:0]), .Busy1(b1_a), .Busy2(b2_a), .Busy_any(ba_a));

   regfile_sb #(.WIDTH(32), .AW(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
      .Clk(Clk), .Clrn(Clrn), .We(We), .Wa(Wa[4:0]), .Wd(Wd[31:0]),
      .Ra1(Ra1[4:0]), .Ra2(Ra2[4:0]), .Rd1(rd1_b), .Rd2(rd2_b),
      .Iss(Iss), .Ia(Ia[4:0]), .Busy1(b1_b), .Busy2(b2_b), .Busy_any(ba_b));

   regfile_sb #(.WIDTH(64), .AW(6), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_c (
      .Clk(Clk), .Clrn(Clrn), .We(We), .Wa(Wa), .Wd(Wd),
      .Ra1(Ra1), .Ra2(Ra2), .Rd1(rd1_c), .Rd2(rd2_c),
      .Iss(Iss), .Ia(Ia), .Busy1(b1_c), .Busy2(b2_c), .Busy_any(ba_c));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [63:0] dmask(int c);
      return (c == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [5:0] amask(int c);
      return (c == 2) ? 6'h3F : 6'h1F;
   endfunction

   function automatic bit has_zero(int c);
      return c != 1;
   endfunction

   function automatic bit has_byp(int c);
      return c != 1;
   endfunction

   function automatic logic [63:0] exp_rd(int c, logic [5:0] ra);
      logic [5:0] a;
      a = ra & amask(c);
      if (has_zero(c) && a == 6'd0) return 64'd0;
      if (has_byp(c) && We && ((Wa & amask(c)) == a)) return Wd & dmask(c);
      return m_mem[c][a];
   endfunction

   function automatic logic [63:0] exp_busy(int c, logic [5:0] ra);
      logic [5:0] a;
      a = ra & amask(c);
      if (has_byp(c) && We && ((Wa & amask(c)) == a)) return 64'd0;
      return {63'd0, m_bsy[c][a]};
   endfunction

   function automatic logic [63:0] exp_any(int c);
      bit r;
      r = 1'b0;
      for (int i = 0; i < 64; i++) r = r | m_bsy[c][i];
      return {63'd0, r};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: async clear, otherwise apply write and scoreboard rules.
   always @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int c = 0; c < 3; c++)
            for (int i = 0; i < 64; i++) begin
               m_mem[c][i] = 64'd0;
               m_bsy[c][i] = 1'b0;
            end
      end else begin
         for (int c = 0; c < 3; c++) begin
            logic [5:0] wa;
            logic [5:0] ia;
            wa = Wa & amask(c);
            ia = Ia & amask(c);
            if (We && !(has_zero(c) && wa == 6'd0)) m_mem[c][wa] = Wd & dmask(c);
            if (We) m_bsy[c][wa] = 1'b0;
            if (Iss && !(has_zero(c) && ia == 6'd0)) m_bsy[c][ia] = 1'b1;
         end
      end
   end

   task automatic cmp_cfg(int c, logic [63:0] r1, logic [63:0] r2,
                          logic b1, logic b2, logic ba);
      chk($sformatf("c%0d Rd1", c), r1, exp_rd(c, Ra1));
      chk($sformatf("c%0d Rd2", c), r2, exp_rd(c, Ra2));
      chk($sformatf("c%0d Busy1", c), {63'd0, b1}, exp_busy(c, Ra1));
      chk($sformatf("c%0d Busy2", c), {63'd0, b2}, exp_busy(c, Ra2));
      chk($sformatf("c%0d Busy_any", c), {63'd0, ba}, exp_any(c));
   endtask

   // Model comparison on every falling edge, mid-cycle with inputs stable.
   always @(negedge Clk) begin
      cmp_cfg(0, {32'd0, rd1_a}, {32'd0, rd2_a}, b1_a, b2_a, ba_a);
      cmp_cfg(1, {32'd0, rd1_b}, {32'd0, rd2_b}, b1_b, b2_b, ba_b);
      cmp_cfg(2, rd1_c, rd2_c, b1_c, b2_c, ba_c);
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      We = 1'b0; Iss = 1'b0; Wa = 6'd0; Ia = 6'd0; Wd = 64'd0;
   endtask

   initial begin
      Clrn = 1'b0; Ra1 = 6'd0; Ra2 = 6'd0;
      idle();
      tick(); tick();
      Clrn = 1'b1;
      #1;
      chk("reset Rd1", {32'd0, rd1_a}, 64'd0);
      chk("reset Busy_any", {63'd0, ba_a}, 64'd0);

      // T1: write r5 then clear mid-cycle without a clock edge.
      We = 1'b1; Wa = 6'd5; Wd = 64'hDEAD_BEEF;
      tick();
      idle(); Ra1 = 6'd5;
      #1;
      chk("T1 r5 written", {32'd0, rd1_a}, 64'hDEAD_BEEF);
      #2;
      Clrn = 1'b0;
      #1;
      chk("T1 async clear a", {32'd0, rd1_a}, 64'd0);
      chk("T1 async clear b", {32'd0, rd1_b}, 64'd0);
      chk("T1 Busy_any", {63'd0, ba_a}, 64'd0);
      tick();
      Clrn = 1'b1;

      // T2: bypass returns new data same cycle, plain config returns old.
      We = 1'b1; Wa = 6'd7; Wd = 64'h1234_5678; Ra1 = 6'd7;
      #1;
      chk("T2 bypass same cycle", {32'd0, rd1_a}, 64'h1234_5678);
      chk("T2 no-bypass old", {32'd0, rd1_b}, 64'd0);
      tick();
      idle();
      #1;
      chk("T2 no-bypass next", {32'd0, rd1_b}, 64'h1234_5678);
      chk("T2 bypass next", {32'd0, rd1_a}, 64'h1234_5678);

      // T3: zero register ignores write and issue; plain config honours both.
      We = 1'b1; Wa = 6'd0; Wd = 64'hFFFF_FFFF_FFFF_FFFF; Iss = 1'b1; Ia = 6'd0; Ra2 = 6'd0;
      tick();
      idle();
      #1;
      chk("T3 zero Rd2", {32'd0, rd2_a}, 64'd0);
      chk("T3 zero Busy2", {63'd0, b2_a}, 64'd0);
      chk("T3 zero Busy_any", {63'd0, ba_a}, 64'd0);
      chk("T3 r0 Rd2", {32'd0, rd2_b}, 64'hFFFF_FFFF);
      chk("T3 r0 Busy2", {63'd0, b2_b}, 64'd1);
      chk("T3 wide zero Rd2", rd2_c, 64'd0);

      // T4: issue, busy next cycle, bypassed writeback hides it.
      Iss = 1'b1; Ia = 6'd3; Ra1 = 6'd3;
      #1;
      chk("T4 issue not yet", {63'd0, b1_a}, 64'd0);
      tick();
      idle();
      #1;
      chk("T4 busy", {63'd0, b1_a}, 64'd1);
      We = 1'b1; Wa = 6'd3; Wd = 64'hA5;
      #1;
      chk("T4 wb hides busy", {63'd0, b1_a}, 64'd0);
      chk("T4 wb bypass data", {32'd0, rd1_a}, 64'hA5);
      chk("T4 no-bypass busy", {63'd0, b1_b}, 64'd1);
      tick();
      idle();
      #1;
      chk("T4 released", {63'd0, b1_a}, 64'd0);
      chk("T4 no-bypass released", {63'd0, b1_b}, 64'd0);
      chk("T4 no-bypass data", {32'd0, rd1_b}, 64'hA5);

      // T5: issue and writeback to r9 on the same edge: set wins, data lands.
      Iss = 1'b1; Ia = 6'd9; We = 1'b1; Wa = 6'd9; Wd = 64'h9999; Ra1 = 6'd9;
      tick();
      idle();
      #1;
      chk("T5 busy kept", {63'd0, b1_a}, 64'd1);
      chk("T5 data", {32'd0, rd1_a}, 64'h9999);
      chk("T5 plain busy kept", {63'd0, b1_b}, 64'd1);
      chk("T5 plain data", {32'd0, rd1_b}, 64'h9999);
      // Re-issue of a busy register leaves it busy.
      Iss = 1'b1; Ia = 6'd9;
      tick();
      idle();
      #1;
      chk("T5 reissue busy", {63'd0, b1_a}, 64'd1);

      // T6: random traffic, addresses biased low so hits are frequent.
      for (int n = 0; n < 3000; n++) begin
         We  = ($urandom % 2) == 0;
         Iss = ($urandom % 3) == 0;
         Wa  = (($urandom % 2) == 0) ? 6'($urandom % 4) : 6'($urandom);
         Ia  = (($urandom % 2) == 0) ? 6'($urandom % 4) : 6'($urandom);
         Ra1 = (($urandom % 2) == 0) ? 6'($urandom % 4) : 6'($urandom);
         Ra2 = (($urandom % 4) == 0) ? Ra1 : 6'($urandom);
         Wd  = {$urandom, $urandom};
         tick();
      end
      idle();
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
